ex_mem_stage: RTL

//  EX->MEM pipeline stage directly downstream of the ALU. Captures ALU result, store data and

---
 rtl/ex_mem_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline register with branch resolution and PC redirect
//
// Purpose:
//   Captures the ALU result, store data and control of the EX instruction into
//   the MEM-side register bundle. Resolves conditional branches from the ALU
//   flags (ALU computes rs1 - rs2) and drives a combinational PC redirect for
//   taken branches and jumps. Supports hold (stall_i) and bubble (flush_i).
//
// Optional feature:
//   BRANCH_STATS_EN - when defined, adds br_count_o / br_taken_o counters of
//   committed conditional branches and of those that were taken.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall_i, flush_i         hazard-unit hold / bubble requests
//   ex_valid_i               EX stage holds a real instruction
//   alu_result_i             ALU result
//   zero_i/neg_i/carry_i/ovf_i  ALU flags (carry_i = unsigned borrow)
//   store_data_i             forwarded rs2 value
//   rd_i, reg_write_i        destination register and its write enable
//   mem_write_i              store enable
//   result_src_i             00 ALU, 01 load, 10 PC+4
//   pc_plus4_i               PC+4 of the EX instruction
//   target_i                 branch/jump target
//   branch_i, jump_i         conditional branch / unconditional jump
//   funct3_i                 branch condition selector
//   redirect_o, redirect_pc_o   combinational PC redirect
//   mem_*_o                  registered MEM-side bundle
//   misalign_o               registered: taken target not word aligned
//   br_count_o, br_taken_o   branch statistics (BRANCH_STATS_EN only)

module ex_mem_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic              zero_i,
    input  logic              neg_i,
    input  logic              carry_i,
    input  logic              ovf_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_write_i,
    input  logic              mem_write_i,
    input  logic [1:0]        result_src_i,
    input  logic [XLEN-1:0]   pc_plus4_i,
    input  logic [XLEN-1:0]   target_i,
    input  logic              branch_i,
    input  logic              jump_i,
    input  logic [2:0]        funct3_i,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              mem_valid_o,
    output logic [1:0]        mem_result_src_o,
    output logic [XLEN-1:0]   mem_alu_result_o,
    output logic [XLEN-1:0]   mem_store_data_o,
    output logic [REG_AW-1:0] mem_rd_o,
    output logic              mem_reg_write_o,
    output logic              mem_mem_write_o,
    output logic [XLEN-1:0]   mem_pc_plus4_o,
    output logic              misalign_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       br_count_o,
    output logic [31:0]       br_taken_o
`endif
);

    logic branch_cond;
    logic taken;
    logic load_en;

    // Flags come from rs1 - rs2: signed less-than is neg^ovf, unsigned
    // less-than is the borrow.
    always_comb begin
        branch_cond = 1'b0;
        case (funct3_i)
            3'b000:  branch_cond = zero_i;
            3'b001:  branch_cond = ~zero_i;
            3'b100:  branch_cond = neg_i ^ ovf_i;
            3'b101:  branch_cond = ~(neg_i ^ ovf_i);
            3'b110:  branch_cond = carry_i;
            3'b111:  branch_cond = ~carry_i;
            default: branch_cond = 1'b0;
        endcase
    end

    // A stalled or flushed instruction never redirects; jump wins over branch.
    assign load_en       = ~stall_i & ~flush_i;
    assign taken         = ex_valid_i & load_en & (jump_i | (branch_i & branch_cond));
    assign redirect_o    = taken;
    assign redirect_pc_o = target_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_o      <= 1'b0;
            mem_result_src_o <= '0;
            mem_alu_result_o <= '0;
            mem_store_data_o <= '0;
            mem_rd_o         <= '0;
            mem_reg_write_o  <= 1'b0;
            mem_mem_write_o  <= 1'b0;
            mem_pc_plus4_o   <= '0;
            misalign_o       <= 1'b0;
        end else if (flush_i) begin
            // Bubble; flush wins over stall. Data fields cleared for tidiness.
            mem_valid_o      <= 1'b0;
            mem_result_src_o <= '0;
            mem_alu_result_o <= '0;
            mem_store_data_o <= '0;
            mem_rd_o         <= '0;
            mem_reg_write_o  <= 1'b0;
            mem_mem_write_o  <= 1'b0;
            mem_pc_plus4_o   <= '0;
            misalign_o       <= 1'b0;
        end else if (!stall_i) begin
            mem_valid_o      <= ex_valid_i;
            mem_result_src_o <= result_src_i;
            mem_alu_result_o <= alu_result_i;
            mem_store_data_o <= store_data_i;
            mem_rd_o         <= rd_i;
            // Write enables are qualified so an invalid slot can never write.
            mem_reg_write_o  <= ex_valid_i & reg_write_i;
            mem_mem_write_o  <= ex_valid_i & mem_write_i;
            mem_pc_plus4_o   <= pc_plus4_i;
            // Redirect still goes out; the trap is raised downstream.
            misalign_o       <= taken & (|target_i[1:0]);
        end
    end

`ifdef BRANCH_STATS_EN
    logic count_branch;

    // Only committed conditional branches count; branch+jump is a jump.
    assign count_branch = ex_valid_i & load_en & branch_i & ~jump_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_o <= '0;
            br_taken_o <= '0;
        end else if (count_branch) begin
            br_count_o <= br_count_o + 32'd1;
            if (branch_cond) begin
                br_taken_o <= br_taken_o + 32'd1;
            end
        end
    end
`endif

endmodule
